inv_sub_bytes_seq: RTL and testbench
====================================

// Module: inv_sub_bytes_seq
// PURPOSE
//  AES-128 decryption InvSubBytes stage: applies the FIPS-197 inverse S-box to all 16 bytes of a 128-bit state.
//  Byte-serial/lane-parallel engine with valid/ready handshakes on both sides; LANES inverse S-box instances are time-shared.
//  Sits in the decrypt round datapath between inv_shift_rows and add_round_key; inverse of the encrypt-side SubBytes.
// PARAMETERS
//  LANES  4  bytes substituted per cycle; legal 1,2,4,8,16; any other value is a compile-time error (generate $error)
//  NCYC   16/LANES (localparam)  processing cycles per block
// PORTS
//  clk        in   1    single clock, all logic on rising edge
//  reset      in   1    synchronous, active-low reset
//  in_valid   in   1    upstream state word valid
//  in_ready   out  1    engine can accept a state word
//  in_state   in   128  input state; byte i = in_state[8i+7:8i]
//  out_valid  out  1    out_state holds a completed result
//  out_ready  in   1    downstream accepts result
//  out_state  out  128  InvSubBytes(in_state), same byte mapping
//  err        out  1    sticky self-check failure flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset (reset==0 at a rising edge): FSM->IDLE, byte counter=0, data reg=0; in_ready=1, out_valid=0, out_state=0, err=0.
//  Reset mid-operation: in-flight block discarded, no out_valid produced for it.
//  FSM: IDLE -> BUSY -> DONE -> IDLE.
//   IDLE: in_ready=1. Edge with in_valid&&in_ready: load in_state into data reg, counter=0, go BUSY.
//   BUSY: in_ready=0, out_valid=0. Each edge: bytes counter*LANES .. counter*LANES+LANES-1 of data reg replaced
//         by inv_sbox(byte) in place; counter++. Edge where counter==NCYC-1: go DONE.
//   DONE: out_valid=1, out_state=data reg, stable until taken. Edge with out_ready: go IDLE (in_ready=1 next cycle).
//  Processing order: lowest byte indices first (byte 0 in the first BUSY cycle).
//  Latency: acceptance edge T -> out_valid high after edge T+NCYC (LANES=4: 4 edges). Throughput 1 block / NCYC+2 cycles min.
//  in_state/in_valid ignored while not IDLE; in_valid high in BUSY/DONE is not accepted (no overwrite, no drop of current).
//  out_ready low holds DONE indefinitely; out_ready high outside DONE has no effect.
//  in_ready and out_valid never both high. out_state is registered (no combinational in->out path).
//  Inverse S-box: full 256-entry combinational case table per lane, exact FIPS-197 InvSbox; no default-reachable entries.
//  Counter width: $clog2(NCYC) bits, minimum 1; LANES=16 means a single BUSY cycle.
// CONFIGURATION
//  INV_SUB_BYTES_SELFCHECK_EN defined: per lane a forward S-box re-encrypts each substituted byte in the same cycle;
//   mismatch vs. original byte sets err=1 on that edge; err sticky until reset. Adds LANES forward S-box tables.
//  Undefined: err tied 0, no forward S-box logic; all other behaviour and timing identical.
// TESTING
//  1) in_state=128'h6363..63 accepted -> after NCYC edges out_valid=1, out_state=128'h0; err=0.
//  2) in_state=128'h0 -> out_state=128'h5252..52; byte-map check: in bytes{0:16,1:7C,2:D4,3:52,rest 63}
//     -> out bytes{0:FF,1:01,2:19,3:48,rest 00}.
//  3) Backpressure: out_ready=0 for 20 cycles in DONE -> out_valid stays 1, out_state stable, in_ready=0, new in_valid ignored.
//  4) Reset low during 2nd BUSY cycle -> next cycle in_ready=1, out_valid=0, out_state=0; following block processes correctly.
//  5) Sweep LANES=1,2,4,8,16 with random states vs. reference model; out_valid exactly NCYC edges after accept.
//  6) With INV_SUB_BYTES_SELFCHECK_EN: all 256 byte values over 16 blocks -> err stays 0; force lane output -> err=1 sticky.

Source files
------------

// File: rtl/inv_sub_bytes_seq.sv
// AES InvSubBytes engine: LANES time-shared inverse S-boxes rewrite a 128-bit state in place over 16/LANES cycles.
// Optional forward-S-box self-check of every substituted byte is enabled with `define INV_SUB_BYTES_SELFCHECK_EN.
module inv_sub_bytes_seq #(
   parameter int LANES = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic         err
);
   localparam int NCYC = 16 / LANES;
   localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

   if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
   end

   // Valid/ready: a word moves on any rising edge where valid and ready are both high;
   // in_ready is high only in IDLE, out_valid only in DONE, so the two never overlap.
   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [127:0]    data_q;
   logic [127:0]    data_nxt;
   logic [7:0]      lane_in  [LANES];
   logic [7:0]      lane_out [LANES];
   logic            last;

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      logic [7:0] r;
      r = 8'h00;
      case (b)
         8'h00: r = 8'h52; 8'h01: r = 8'h09; 8'h02: r = 8'h6a; 8'h03: r = 8'hd5; 8'h04: r = 8'h30; 8'h05: r = 8'h36; 8'h06: r = 8'ha5; 8'h07: r = 8'h38;
         8'h08: r = 8'hbf; 8'h09: r = 8'h40; 8'h0a: r = 8'ha3; 8'h0b: r = 8'h9e; 8'h0c: r = 8'h81; 8'h0d: r = 8'hf3; 8'h0e: r = 8'hd7; 8'h0f: r = 8'hfb;
         8'h10: r = 8'h7c; 8'h11: r = 8'he3; 8'h12: r = 8'h39; 8'h13: r = 8'h82; 8'h14: r = 8'h9b; 8'h15: r = 8'h2f; 8'h16: r = 8'hff; 8'h17: r = 8'h87;
         8'h18: r = 8'h34; 8'h19: r = 8'h8e; 8'h1a: r = 8'h43; 8'h1b: r = 8'h44; 8'h1c: r = 8'hc4; 8'h1d: r = 8'hde; 8'h1e: r = 8'he9; 8'h1f: r = 8'hcb;
         8'h20: r = 8'h54; 8'h21: r = 8'h7b; 8'h22: r = 8'h94; 8'h23: r = 8'h32; 8'h24: r = 8'ha6; 8'h25: r = 8'hc2; 8'h26: r = 8'h23; 8'h27: r = 8'h3d;
         8'h28: r = 8'hee; 8'h29: r = 8'h4c; 8'h2a: r = 8'h95; 8'h2b: r = 8'h0b; 8'h2c: r = 8'h42; 8'h2d: r = 8'hfa; 8'h2e: r = 8'hc3; 8'h2f: r = 8'h4e;
         8'h30: r = 8'h08; 8'h31: r = 8'h2e; 8'h32: r = 8'ha1; 8'h33: r = 8'h66; 8'h34: r = 8'h28; 8'h35: r = 8'hd9; 8'h36: r = 8'h24; 8'h37: r = 8'hb2;
         8'h38: r = 8'h76; 8'h39: r = 8'h5b; 8'h3a: r = 8'ha2; 8'h3b: r = 8'h49; 8'h3c: r = 8'h6d; 8'h3d: r = 8'h8b; 8'h3e: r = 8'hd1; 8'h3f: r = 8'h25;
         8'h40: r = 8'h72; 8'h41: r = 8'hf8; 8'h42: r = 8'hf6; 8'h43: r = 8'h64; 8'h44: r = 8'h86; 8'h45: r = 8'h68; 8'h46: r = 8'h98; 8'h47: r = 8'h16;
         8'h48: r = 8'hd4; 8'h49: r = 8'ha4; 8'h4a: r = 8'h5c; 8'h4b: r = 8'hcc; 8'h4c: r = 8'h5d; 8'h4d: r = 8'h65; 8'h4e: r = 8'hb6; 8'h4f: r = 8'h92;
         8'h50: r = 8'h6c; 8'h51: r = 8'h70; 8'h52: r = 8'h48; 8'h53: r = 8'h50; 8'h54: r = 8'hfd; 8'h55: r = 8'hed; 8'h56: r = 8'hb9; 8'h57: r = 8'hda;
         8'h58: r = 8'h5e; 8'h59: r = 8'h15; 8'h5a: r = 8'h46; 8'h5b: r = 8'h57; 8'h5c: r = 8'ha7; 8'h5d: r = 8'h8d; 8'h5e: r = 8'h9d; 8'h5f: r = 8'h84;
         8'h60: r = 8'h90; 8'h61: r = 8'hd8; 8'h62: r = 8'hab; 8'h63: r = 8'h00; 8'h64: r = 8'h8c; 8'h65: r = 8'hbc; 8'h66: r = 8'hd3; 8'h67: r = 8'h0a;
         8'h68: r = 8'hf7; 8'h69: r = 8'he4; 8'h6a: r = 8'h58; 8'h6b: r = 8'h05; 8'h6c: r = 8'hb8; 8'h6d: r = 8'hb3; 8'h6e: r = 8'h45; 8'h6f: r = 8'h06;
         8'h70: r = 8'hd0; 8'h71: r = 8'h2c; 8'h72: r = 8'h1e; 8'h73: r = 8'h8f; 8'h74: r = 8'hca; 8'h75: r = 8'h3f; 8'h76: r = 8'h0f; 8'h77: r = 8'h02;
         8'h78: r = 8'hc1; 8'h79: r = 8'haf; 8'h7a: r = 8'hbd; 8'h7b: r = 8'h03; 8'h7c: r = 8'h01; 8'h7d: r = 8'h13; 8'h7e: r = 8'h8a; 8'h7f: r = 8'h6b;
         8'h80: r = 8'h3a; 8'h81: r = 8'h91; 8'h82: r = 8'h11; 8'h83: r = 8'h41; 8'h84: r = 8'h4f; 8'h85: r = 8'h67; 8'h86: r = 8'hdc; 8'h87: r = 8'hea;
         8'h88: r = 8'h97; 8'h89: r = 8'hf2; 8'h8a: r = 8'hcf; 8'h8b: r = 8'hce; 8'h8c: r = 8'hf0; 8'h8d: r = 8'hb4; 8'h8e: r = 8'he6; 8'h8f: r = 8'h73;
         8'h90: r = 8'h96; 8'h91: r = 8'hac; 8'h92: r = 8'h74; 8'h93: r = 8'h22; 8'h94: r = 8'he7; 8'h95: r = 8'had; 8'h96: r = 8'h35; 8'h97: r = 8'h85;
         8'h98: r = 8'he2; 8'h99: r = 8'hf9; 8'h9a: r = 8'h37; 8'h9b: r = 8'he8; 8'h9c: r = 8'h1c; 8'h9d: r = 8'h75; 8'h9e: r = 8'hdf; 8'h9f: r = 8'h6e;
         8'ha0: r = 8'h47; 8'ha1: r = 8'hf1; 8'ha2: r = 8'h1a; 8'ha3: r = 8'h71; 8'ha4: r = 8'h1d; 8'ha5: r = 8'h29; 8'ha6: r = 8'hc5; 8'ha7: r = 8'h89;
         8'ha8: r = 8'h6f; 8'ha9: r = 8'hb7; 8'haa: r = 8'h62; 8'hab: r = 8'h0e; 8'hac: r = 8'haa; 8'had: r = 8'h18; 8'hae: r = 8'hbe; 8'haf: r = 8'h1b;
         8'hb0: r = 8'hfc; 8'hb1: r = 8'h56; 8'hb2: r = 8'h3e; 8'hb3: r = 8'h4b; 8'hb4: r = 8'hc6; 8'hb5: r = 8'hd2; 8'hb6: r = 8'h79; 8'hb7: r = 8'h20;
         8'hb8: r = 8'h9a; 8'hb9: r = 8'hdb; 8'hba: r = 8'hc0; 8'hbb: r = 8'hfe; 8'hbc: r = 8'h78; 8'hbd: r = 8'hcd; 8'hbe: r = 8'h5a; 8'hbf: r = 8'hf4;
         8'hc0: r = 8'h1f; 8'hc1: r = 8'hdd; 8'hc2: r = 8'ha8; 8'hc3: r = 8'h33; 8'hc4: r = 8'h88; 8'hc5: r = 8'h07; 8'hc6: r = 8'hc7; 8'hc7: r = 8'h31;
         8'hc8: r = 8'hb1; 8'hc9: r = 8'h12; 8'hca: r = 8'h10; 8'hcb: r = 8'h59; 8'hcc: r = 8'h27; 8'hcd: r = 8'h80; 8'hce: r = 8'hec; 8'hcf: r = 8'h5f;
         8'hd0: r = 8'h60; 8'hd1: r = 8'h51; 8'hd2: r = 8'h7f; 8'hd3: r = 8'ha9; 8'hd4: r = 8'h19; 8'hd5: r = 8'hb5; 8'hd6: r = 8'h4a; 8'hd7: r = 8'h0d;
         8'hd8: r = 8'h2d; 8'hd9: r = 8'he5; 8'hda: r = 8'h7a; 8'hdb: r = 8'h9f; 8'hdc: r = 8'h93; 8'hdd: r = 8'hc9; 8'hde: r = 8'h9c; 8'hdf: r = 8'hef;
         8'he0: r = 8'ha0; 8'he1: r = 8'he0; 8'he2: r = 8'h3b; 8'he3: r = 8'h4d; 8'he4: r = 8'hae; 8'he5: r = 8'h2a; 8'he6: r = 8'hf5; 8'he7: r = 8'hb0;
         8'he8: r = 8'hc8; 8'he9: r = 8'heb; 8'hea: r = 8'hbb; 8'heb: r = 8'h3c; 8'hec: r = 8'h83; 8'hed: r = 8'h53; 8'hee: r = 8'h99; 8'hef: r = 8'h61;
         8'hf0: r = 8'h17; 8'hf1: r = 8'h2b; 8'hf2: r = 8'h04; 8'hf3: r = 8'h7e; 8'hf4: r = 8'hba; 8'hf5: r = 8'h77; 8'hf6: r = 8'hd6; 8'hf7: r = 8'h26;
         8'hf8: r = 8'he1; 8'hf9: r = 8'h69; 8'hfa: r = 8'h14; 8'hfb: r = 8'h63; 8'hfc: r = 8'h55; 8'hfd: r = 8'h21; 8'hfe: r = 8'h0c; 8'hff: r = 8'h7d;
      endcase
      return r;
   endfunction

   assign last = (cnt == CW'(NCYC - 1));

   // Each lane picks its byte from the group addressed by cnt; group g covers bytes g*LANES .. g*LANES+LANES-1.
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         lane_in[l] = 8'h00;
         for (int g = 0; g < NCYC; g++)
            if (cnt == CW'(g)) lane_in[l] = data_q[(g*LANES+l)*8 +: 8];
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign lane_out[l] = inv_sbox(lane_in[l]);
   end

   always_comb begin
      data_nxt = data_q;
      for (int g = 0; g < NCYC; g++)
         for (int l = 0; l < LANES; l++)
            if (cnt == CW'(g)) data_nxt[(g*LANES+l)*8 +: 8] = lane_out[l];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= S_IDLE;
         cnt       <= '0;
         data_q    <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_state <= '0;
      end else begin
         case (state)
            S_IDLE: if (in_valid) begin
               data_q   <= in_state;
               cnt      <= '0;
               in_ready <= 1'b0;
               state    <= S_BUSY;
            end
            S_BUSY: begin
               data_q <= data_nxt;
               cnt    <= cnt + CW'(1);
               if (last) begin
                  state     <= S_DONE;
                  out_valid <= 1'b1;
                  out_state <= data_nxt;
               end
            end
            S_DONE: if (out_ready) begin
               state     <= S_IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef INV_SUB_BYTES_SELFCHECK_EN
   function automatic logic [7:0] fwd_sbox(input logic [7:0] b);
      logic [7:0] r;
      r = 8'h00;
      case (b)
         8'h00: r = 8'h63; 8'h01: r = 8'h7c; 8'h02: r = 8'h77; 8'h03: r = 8'h7b; 8'h04: r = 8'hf2; 8'h05: r = 8'h6b; 8'h06: r = 8'h6f; 8'h07: r = 8'hc5;
         8'h08: r = 8'h30; 8'h09: r = 8'h01; 8'h0a: r = 8'h67; 8'h0b: r = 8'h2b; 8'h0c: r = 8'hfe; 8'h0d: r = 8'hd7; 8'h0e: r = 8'hab; 8'h0f: r = 8'h76;
         8'h10: r = 8'hca; 8'h11: r = 8'h82; 8'h12: r = 8'hc9; 8'h13: r = 8'h7d; 8'h14: r = 8'hfa; 8'h15: r = 8'h59; 8'h16: r = 8'h47; 8'h17: r = 8'hf0;
         8'h18: r = 8'had; 8'h19: r = 8'hd4; 8'h1a: r = 8'ha2; 8'h1b: r = 8'haf; 8'h1c: r = 8'h9c; 8'h1d: r = 8'ha4; 8'h1e: r = 8'h72; 8'h1f: r = 8'hc0;
         8'h20: r = 8'hb7; 8'h21: r = 8'hfd; 8'h22: r = 8'h93; 8'h23: r = 8'h26; 8'h24: r = 8'h36; 8'h25: r = 8'h3f; 8'h26: r = 8'hf7; 8'h27: r = 8'hcc;
         8'h28: r = 8'h34; 8'h29: r = 8'ha5; 8'h2a: r = 8'he5; 8'h2b: r = 8'hf1; 8'h2c: r = 8'h71; 8'h2d: r = 8'hd8; 8'h2e: r = 8'h31; 8'h2f: r = 8'h15;
         8'h30: r = 8'h04; 8'h31: r = 8'hc7; 8'h32: r = 8'h23; 8'h33: r = 8'hc3; 8'h34: r = 8'h18; 8'h35: r = 8'h96; 8'h36: r = 8'h05; 8'h37: r = 8'h9a;
         8'h38: r = 8'h07; 8'h39: r = 8'h12; 8'h3a: r = 8'h80; 8'h3b: r = 8'he2; 8'h3c: r = 8'heb; 8'h3d: r = 8'h27; 8'h3e: r = 8'hb2; 8'h3f: r = 8'h75;
         8'h40: r = 8'h09; 8'h41: r = 8'h83; 8'h42: r = 8'h2c; 8'h43: r = 8'h1a; 8'h44: r = 8'h1b; 8'h45: r = 8'h6e; 8'h46: r = 8'h5a; 8'h47: r = 8'ha0;
         8'h48: r = 8'h52; 8'h49: r = 8'h3b; 8'h4a: r = 8'hd6; 8'h4b: r = 8'hb3; 8'h4c: r = 8'h29; 8'h4d: r = 8'he3; 8'h4e: r = 8'h2f; 8'h4f: r = 8'h84;
         8'h50: r = 8'h53; 8'h51: r = 8'hd1; 8'h52: r = 8'h00; 8'h53: r = 8'hed; 8'h54: r = 8'h20; 8'h55: r = 8'hfc; 8'h56: r = 8'hb1; 8'h57: r = 8'h5b;
         8'h58: r = 8'h6a; 8'h59: r = 8'hcb; 8'h5a: r = 8'hbe; 8'h5b: r = 8'h39; 8'h5c: r = 8'h4a; 8'h5d: r = 8'h4c; 8'h5e: r = 8'h58; 8'h5f: r = 8'hcf;
         8'h60: r = 8'hd0; 8'h61: r = 8'hef; 8'h62: r = 8'haa; 8'h63: r = 8'hfb; 8'h64: r = 8'h43; 8'h65: r = 8'h4d; 8'h66: r = 8'h33; 8'h67: r = 8'h85;
         8'h68: r = 8'h45; 8'h69: r = 8'hf9; 8'h6a: r = 8'h02; 8'h6b: r = 8'h7f; 8'h6c: r = 8'h50; 8'h6d: r = 8'h3c; 8'h6e: r = 8'h9f; 8'h6f: r = 8'ha8;
         8'h70: r = 8'h51; 8'h71: r = 8'ha3; 8'h72: r = 8'h40; 8'h73: r = 8'h8f; 8'h74: r = 8'h92; 8'h75: r = 8'h9d; 8'h76: r = 8'h38; 8'h77: r = 8'hf5;
         8'h78: r = 8'hbc; 8'h79: r = 8'hb6; 8'h7a: r = 8'hda; 8'h7b: r = 8'h21; 8'h7c: r = 8'h10; 8'h7d: r = 8'hff; 8'h7e: r = 8'hf3; 8'h7f: r = 8'hd2;
         8'h80: r = 8'hcd; 8'h81: r = 8'h0c; 8'h82: r = 8'h13; 8'h83: r = 8'hec; 8'h84: r = 8'h5f; 8'h85: r = 8'h97; 8'h86: r = 8'h44; 8'h87: r = 8'h17;
         8'h88: r = 8'hc4; 8'h89: r = 8'ha7; 8'h8a: r = 8'h7e; 8'h8b: r = 8'h3d; 8'h8c: r = 8'h64; 8'h8d: r = 8'h5d; 8'h8e: r = 8'h19; 8'h8f: r = 8'h73;
         8'h90: r = 8'h60; 8'h91: r = 8'h81; 8'h92: r = 8'h4f; 8'h93: r = 8'hdc; 8'h94: r = 8'h22; 8'h95: r = 8'h2a; 8'h96: r = 8'h90; 8'h97: r = 8'h88;
         8'h98: r = 8'h46; 8'h99: r = 8'hee; 8'h9a: r = 8'hb8; 8'h9b: r = 8'h14; 8'h9c: r = 8'hde; 8'h9d: r = 8'h5e; 8'h9e: r = 8'h0b; 8'h9f: r = 8'hdb;
         8'ha0: r = 8'he0; 8'ha1: r = 8'h32; 8'ha2: r = 8'h3a; 8'ha3: r = 8'h0a; 8'ha4: r = 8'h49; 8'ha5: r = 8'h06; 8'ha6: r = 8'h24; 8'ha7: r = 8'h5c;
         8'ha8: r = 8'hc2; 8'ha9: r = 8'hd3; 8'haa: r = 8'hac; 8'hab: r = 8'h62; 8'hac: r = 8'h91; 8'had: r = 8'h95; 8'hae: r = 8'he4; 8'haf: r = 8'h79;
         8'hb0: r = 8'he7; 8'hb1: r = 8'hc8; 8'hb2: r = 8'h37; 8'hb3: r = 8'h6d; 8'hb4: r = 8'h8d; 8'hb5: r = 8'hd5; 8'hb6: r = 8'h4e; 8'hb7: r = 8'ha9;
         8'hb8: r = 8'h6c; 8'hb9: r = 8'h56; 8'hba: r = 8'hf4; 8'hbb: r = 8'hea; 8'hbc: r = 8'h65; 8'hbd: r = 8'h7a; 8'hbe: r = 8'hae; 8'hbf: r = 8'h08;
         8'hc0: r = 8'hba; 8'hc1: r = 8'h78; 8'hc2: r = 8'h25; 8'hc3: r = 8'h2e; 8'hc4: r = 8'h1c; 8'hc5: r = 8'ha6; 8'hc6: r = 8'hb4; 8'hc7: r = 8'hc6;
         8'hc8: r = 8'he8; 8'hc9: r = 8'hdd; 8'hca: r = 8'h74; 8'hcb: r = 8'h1f; 8'hcc: r = 8'h4b; 8'hcd: r = 8'hbd; 8'hce: r = 8'h8b; 8'hcf: r = 8'h8a;
         8'hd0: r = 8'h70; 8'hd1: r = 8'h3e; 8'hd2: r = 8'hb5; 8'hd3: r = 8'h66; 8'hd4: r = 8'h48; 8'hd5: r = 8'h03; 8'hd6: r = 8'hf6; 8'hd7: r = 8'h0e;
         8'hd8: r = 8'h61; 8'hd9: r = 8'h35; 8'hda: r = 8'h57; 8'hdb: r = 8'hb9; 8'hdc: r = 8'h86; 8'hdd: r = 8'hc1; 8'hde: r = 8'h1d; 8'hdf: r = 8'h9e;
         8'he0: r = 8'he1; 8'he1: r = 8'hf8; 8'he2: r = 8'h98; 8'he3: r = 8'h11; 8'he4: r = 8'h69; 8'he5: r = 8'hd9; 8'he6: r = 8'h8e; 8'he7: r = 8'h94;
         8'he8: r = 8'h9b; 8'he9: r = 8'h1e; 8'hea: r = 8'h87; 8'heb: r = 8'he9; 8'hec: r = 8'hce; 8'hed: r = 8'h55; 8'hee: r = 8'h28; 8'hef: r = 8'hdf;
         8'hf0: r = 8'h8c; 8'hf1: r = 8'ha1; 8'hf2: r = 8'h89; 8'hf3: r = 8'h0d; 8'hf4: r = 8'hbf; 8'hf5: r = 8'he6; 8'hf6: r = 8'h42; 8'hf7: r = 8'h68;
         8'hf8: r = 8'h41; 8'hf9: r = 8'h99; 8'hfa: r = 8'h2d; 8'hfb: r = 8'h0f; 8'hfc: r = 8'hb0; 8'hfd: r = 8'h54; 8'hfe: r = 8'hbb; 8'hff: r = 8'h16;
      endcase
      return r;
   endfunction

   logic [LANES-1:0] chk_bad;

   for (genvar l = 0; l < LANES; l++) begin : g_chk
      assign chk_bad[l] = (fwd_sbox(lane_out[l]) != lane_in[l]);
   end

   // Sticky: once any lane fails to round-trip, err stays high until reset.
   always_ff @(posedge clk) begin
      if (!reset)                          err <= 1'b0;
      else if (state == S_BUSY && |chk_bad) err <= 1'b1;
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Randomized bench for inv_sub_bytes_seq; the reference inverse S-box is derived from GF(2^8) inversion plus
// the AES affine map, then inverted, so it shares nothing with the design's lookup table.
module tb_inv_sub_bytes_seq;
   parameter int LANES = 4;
   localparam int NCYC = 16 / LANES;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_state;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_state;
   logic         err;

   int n_checks = 0;
   int n_errors = 0;
   logic [127:0] exp_q[$];
   logic [7:0]   inv_tab [256];

   inv_sub_bytes_seq #(.LANES(LANES)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_state  (in_state),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_state (out_state),
      .err       (err)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got=running exp=finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p = 8'h00; aa = a; bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] r;
      r = 8'h00;
      for (int y = 1; y < 256; y++)
         if (a != 8'h00 && gmul(a, 8'(y)) == 8'h01) r = 8'(y);
      return r;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
      logic [15:0] t;
      t = {b, b} << k;
      return t[15:8];
   endfunction

   function automatic logic [7:0] fwd_model(input logic [7:0] x);
      logic [7:0] b;
      b = ginv(x);
      return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
   endfunction

   task automatic build_model();
      for (int x = 0; x < 256; x++) inv_tab[fwd_model(8'(x))] = 8'(x);
   endtask

   function automatic logic [127:0] ref_inv(input logic [127:0] s);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_tab[s[8*i +: 8]];
      return r;
   endfunction

   function automatic logic [127:0] rand_state();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- driver ----------------
   // Drives one block, optionally toggles in_valid/in_state junk while the engine is busy or stalled.
   task automatic run_block(input logic [127:0] st, input logic [127:0] exp, input int hold, input bit noise);
      int wait_n;
      int lat;
      wait_n = 0;
      while (!in_ready && wait_n < 100) begin
         @(negedge clk);
         wait_n++;
      end
      check("in_ready_idle", 128'(in_ready), 128'(1));
      in_valid = 1'b1;
      in_state = st;
      exp_q.push_back(exp);
      @(negedge clk);
      lat = 0;
      while (!out_valid && lat < 100) begin
         check("in_ready_busy", 128'(in_ready), 128'(0));
         in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         in_state = rand_state();
         @(negedge clk);
         lat++;
      end
      check("latency", 128'(lat), 128'(NCYC));
      for (int h = 0; h < hold; h++) begin
         in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         in_state = rand_state();
         @(negedge clk);
         check("hold_out_valid", 128'(out_valid), 128'(1));
         check("hold_in_ready", 128'(in_ready), 128'(0));
         check("hold_out_state", out_state, exp_q[0]);
      end
      out_ready = 1'b1;
      check("out_state", out_state, exp_q.pop_front());
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check("out_valid_after_take", 128'(out_valid), 128'(0));
      check("in_ready_after_take", 128'(in_ready), 128'(1));
   endtask

   initial begin
      logic [127:0] st;
      reset     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_state  = '0;
      build_model();
      repeat (3) @(negedge clk);
      check("rst_in_ready", 128'(in_ready), 128'(1));
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_out_state", out_state, 128'h0);
      check("rst_err", 128'(err), 128'(0));
      reset = 1'b1;
      @(negedge clk);

      // directed values
      run_block({16{8'h63}}, 128'h0, 0, 0);
      check("err_after_63", 128'(err), 128'(0));
      run_block(128'h0, {16{8'h52}}, 0, 0);
      run_block({{12{8'h63}}, 8'h52, 8'hd4, 8'h7c, 8'h16}, {96'h0, 8'h48, 8'h19, 8'h01, 8'hff}, 0, 0);

      // backpressure: DONE held 20 cycles with junk on the input side
      st = rand_state();
      run_block(st, ref_inv(st), 20, 1);

      // reset during the second BUSY cycle
      in_valid = 1'b1;
      in_state = rand_state();
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check("midrst_in_ready", 128'(in_ready), 128'(1));
      check("midrst_out_valid", 128'(out_valid), 128'(0));
      check("midrst_out_state", out_state, 128'h0);
      check("midrst_err", 128'(err), 128'(0));
      repeat (NCYC + 2) begin
         @(negedge clk);
         check("midrst_no_output", 128'(out_valid), 128'(0));
      end
      st = rand_state();
      run_block(st, ref_inv(st), 1, 0);

      // every byte value once over 16 blocks
      for (int k = 0; k < 16; k++) begin
         for (int i = 0; i < 16; i++) st[8*i +: 8] = 8'(k*16 + i);
         run_block(st, ref_inv(st), 0, 0);
      end
      check("err_after_sweep", 128'(err), 128'(0));

      // random blocks with random stalls and input noise
      for (int n = 0; n < 30; n++) begin
         st = rand_state();
         run_block(st, ref_inv(st), $urandom_range(0, 3), 1);
      end
      check("err_final", 128'(err), 128'(0));
      check("scoreboard_empty", 128'(exp_q.size()), 128'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
